// File: rtl/multiport_mem_responder_pkg.sv
// Shared constants and helpers for the multiport memory responder.
// Contains default widths, the read/write encoding and grant-index sizing.
package mem_pkg;

    localparam int MEM_WIDTH  = 12;
    localparam int ADDR_WIDTH = 12;
    localparam int PORT_COUNT = 2;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Grant index needs at least one bit even for a single port.
    function automatic int gw_of(input int ports);
        return (ports > 1) ? clog2(ports) : 1;
    endfunction

    localparam int GW = gw_of(PORT_COUNT);

endpackage

// File: rtl/multiport_mem_responder_if.sv
// Flattened per-core request/response bus between processor cores and the responder.
interface multiport_mem_responder_if #(
    parameter int PORT_COUNT = mem_pkg::PORT_COUNT,
    parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
    parameter int MEM_WIDTH  = mem_pkg::MEM_WIDTH
) ();
    localparam int GW = mem_pkg::gw_of(PORT_COUNT);

    logic [PORT_COUNT-1:0]            req;
    logic [PORT_COUNT-1:0]            wr;
    logic [ADDR_WIDTH*PORT_COUNT-1:0] address;
    logic [MEM_WIDTH*PORT_COUNT-1:0]  datain;
    logic [PORT_COUNT-1:0]            ack;
    logic [PORT_COUNT-1:0]            err;
    logic [MEM_WIDTH*PORT_COUNT-1:0]  dataout;
    logic [GW-1:0]                    grant_id;

    modport master (
        output req, wr, address, datain,
        input  ack, err, dataout, grant_id
    );

    modport slave (
        input  req, wr, address, datain,
        output ack, err, dataout, grant_id
    );

endinterface

// File: rtl/multiport_mem_responder_rr_arbiter.sv
// Round-robin arbiter: grants the first eligible port at or after rr_ptr, cyclically.
module rr_arbiter
    import mem_pkg::*;
#(
    parameter int PORT_COUNT = 2,
    localparam int GW = gw_of(PORT_COUNT)
) (
    input  logic [PORT_COUNT-1:0] eligible,
    input  logic [GW-1:0]         rr_ptr,
    output logic                  grant_valid,
    output logic [GW-1:0]         grant_idx
);

    logic [GW-1:0] cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < PORT_COUNT; k++) begin
            cand = GW'((int'(rr_ptr) + k) % PORT_COUNT);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/multiport_mem_responder.sv
// Serialises per-core read/write requests onto one single-port storage array,
// returning a one-cycle ack (plus err/read data) to the served core.
module multiport_mem_responder
    import mem_pkg::*;
#(
    parameter int mem_size   = 4096,
    parameter int mem_width  = MEM_WIDTH,
    parameter int addr_width = ADDR_WIDTH,
    parameter int port_count = 2,
    localparam int GWL = gw_of(port_count)
) (
    input  logic                      clk,
    input  logic                      reset,
    multiport_mem_responder_if.slave  bus
);

    localparam logic [31:0] MEM_LIMIT = 32'(mem_size);

    logic [mem_width-1:0]             mem_q [mem_size];

    logic [port_count-1:0]            ack_q, ack_d;
    logic [port_count-1:0]            err_q, err_d;
    logic [mem_width*port_count-1:0]  dataout_q, dataout_d;
    logic [GWL-1:0]                   grant_id_q, grant_id_d;
    logic [GWL-1:0]                   rr_ptr_q, rr_ptr_d;

    logic [port_count-1:0]            eligible;
    logic                             grant_valid;
    logic [GWL-1:0]                   grant_idx;
    logic [addr_width-1:0]            addr_g;
    logic [mem_width-1:0]             data_g;
    logic                             wr_g;
    logic                             in_range;

    // A port being acked this cycle is masked so a dropping requester is never served twice.
    assign eligible = bus.req & ~ack_q;

    rr_arbiter #(.PORT_COUNT(port_count)) u_arb (
        .eligible    (eligible),
        .rr_ptr      (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign addr_g   = bus.address[grant_idx*addr_width +: addr_width];
    assign data_g   = bus.datain[grant_idx*mem_width +: mem_width];
    assign wr_g     = bus.wr[grant_idx];
    assign in_range = (32'(addr_g) < MEM_LIMIT);

    always_comb begin
        ack_d      = '0;
        err_d      = '0;
        dataout_d  = dataout_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        if (grant_valid) begin
            ack_d[grant_idx] = 1'b1;
            grant_id_d       = grant_idx;
            rr_ptr_d         = (int'(grant_idx) == port_count - 1) ? '0 : grant_idx + 1'b1;
            if (!in_range) begin
                err_d[grant_idx]                               = 1'b1;
                dataout_d[grant_idx*mem_width +: mem_width]    = '0;
            end else if (wr_g == RD) begin
                dataout_d[grant_idx*mem_width +: mem_width]    = mem_q[addr_g];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q      <= '0;
            err_q      <= '0;
            dataout_q  <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            ack_q      <= ack_d;
            err_q      <= err_d;
            dataout_q  <= dataout_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Storage is never cleared; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (!reset && grant_valid && in_range && wr_g == WR)
            mem_q[addr_g] <= data_g;
    end

    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.dataout  = dataout_q;
    assign bus.grant_id = grant_id_q;

endmodule

// File: tb/tb_multiport_mem_responder.sv
// Directed bench for the two-port memory responder with storage limited to 4000 words.
module tb_multiport_mem_responder;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    multiport_mem_responder_if #(.PORT_COUNT(2), .ADDR_WIDTH(12), .MEM_WIDTH(12)) bus ();

    multiport_mem_responder #(
        .mem_size   (4000),
        .mem_width  (12),
        .addr_width (12),
        .port_count (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset       = 1'b1;
        bus.req     = 2'b00;
        bus.wr      = 2'b00;
        bus.address = '0;
        bus.datain  = '0;

        #12;
        chk("rst_ack", 32'(bus.ack), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        chk("rst_dout", 32'(bus.dataout), 32'h0);
        chk("rst_gid", 32'(bus.grant_id), 32'h0);
        reset = 1'b0;

        // port0 write addr 5 = 0xABC
        bus.req = 2'b01; bus.wr = 2'b01; bus.address = {12'd0, 12'd5}; bus.datain = {12'h000, 12'hABC};
        tick();
        chk("wr5_ack", 32'(bus.ack), 32'h1);
        chk("wr5_err", 32'(bus.err), 32'h0);
        chk("wr5_dout_kept", 32'(bus.dataout[11:0]), 32'h0);
        bus.req = 2'b00;
        tick();
        chk("wr5_ack_drop", 32'(bus.ack), 32'h0);

        // port0 read addr 5
        bus.req = 2'b01; bus.wr = 2'b00; bus.address = {12'd0, 12'd5};
        tick();
        chk("rd5_ack", 32'(bus.ack), 32'h1);
        chk("rd5_data", 32'(bus.dataout[11:0]), 32'hABC);

        // asynchronous reset while ack and dataout are non-zero
        #1 reset = 1'b1;
        #1;
        chk("async_rst_ack", 32'(bus.ack), 32'h0);
        chk("async_rst_dout", 32'(bus.dataout), 32'h0);
        chk("async_rst_gid", 32'(bus.grant_id), 32'h0);
        bus.req = 2'b00;
        #2 reset = 1'b0;
        tick();

        // collision: port0 writes 7=0x111, port1 reads 7
        bus.req = 2'b11; bus.wr = 2'b01; bus.address = {12'd7, 12'd7}; bus.datain = {12'h000, 12'h111};
        tick();
        chk("col_ack0", 32'(bus.ack), 32'h1);
        chk("col_gid0", 32'(bus.grant_id), 32'h0);
        bus.req = 2'b10;
        tick();
        chk("col_ack1", 32'(bus.ack), 32'h2);
        chk("col_gid1", 32'(bus.grant_id), 32'h1);
        chk("col_data1", 32'(bus.dataout[23:12]), 32'h111);
        bus.req = 2'b00;
        tick();
        chk("col_idle", 32'(bus.ack), 32'h0);

        // fairness: both read continuously
        bus.req = 2'b11; bus.wr = 2'b00; bus.address = {12'd7, 12'd5};
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("fair_gid", 32'(bus.grant_id), 32'(i % 2));
            chk("fair_ack", 32'(bus.ack), 32'(1 << (i % 2)));
        end
        chk("fair_d0", 32'(bus.dataout[11:0]), 32'hABC);
        chk("fair_d1", 32'(bus.dataout[23:12]), 32'h111);
        bus.req = 2'b00;
        tick();
        chk("fair_idle_ack", 32'(bus.ack), 32'h0);
        chk("fair_idle_gid", 32'(bus.grant_id), 32'h1);

        // out of range read by port1 (0xFA0 = 4000)
        bus.req = 2'b10; bus.wr = 2'b00; bus.address = {12'hFA0, 12'd5};
        tick();
        chk("oor_ack", 32'(bus.ack), 32'h2);
        chk("oor_err", 32'(bus.err), 32'h2);
        chk("oor_d1", 32'(bus.dataout[23:12]), 32'h0);
        chk("oor_d0_kept", 32'(bus.dataout[11:0]), 32'hABC);

        // port0 write addr 9 = 0x5A5 must leave dataout unchanged
        bus.req = 2'b01; bus.wr = 2'b01; bus.address = {12'd0, 12'd9}; bus.datain = {12'h000, 12'h5A5};
        tick();
        chk("wr9_ack", 32'(bus.ack), 32'h1);
        chk("wr9_err", 32'(bus.err), 32'h0);
        chk("wr9_d0_kept", 32'(bus.dataout[11:0]), 32'hABC);
        bus.req = 2'b00;
        tick();

        // storage at 7 untouched by the out-of-range access
        bus.req = 2'b10; bus.wr = 2'b00; bus.address = {12'd7, 12'd0};
        tick();
        chk("oor_mem7", 32'(bus.dataout[23:12]), 32'h111);
        bus.req = 2'b00;
        tick();

        // reset across an edge while port0 read of addr 9 is pending
        bus.req = 2'b01; bus.wr = 2'b00; bus.address = {12'd0, 12'd9};
        #2 reset = 1'b1;
        tick();
        chk("rstpend_ack", 32'(bus.ack), 32'h0);
        reset = 1'b0;
        tick();
        chk("rstpend_ack_after", 32'(bus.ack), 32'h1);
        chk("rstpend_data", 32'(bus.dataout[11:0]), 32'h5A5);
        bus.req = 2'b00;
        tick();

        // single port holding req: served every other cycle
        bus.req = 2'b01; bus.wr = 2'b00; bus.address = {12'd0, 12'd7};
        tick(); chk("b2b_ack_a", 32'(bus.ack), 32'h1);
        tick(); chk("b2b_ack_b", 32'(bus.ack), 32'h0);
        tick(); chk("b2b_ack_c", 32'(bus.ack), 32'h1);
        tick(); chk("b2b_ack_d", 32'(bus.ack), 32'h0);
        chk("b2b_data", 32'(bus.dataout[11:0]), 32'h111);
        bus.req = 2'b00;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multiport_mem_responder.md
Name: multiport_mem_responder

Overview:
- Responder end of the per-core data-memory interface: accepts read/write requests from `port_count` processor cores on flattened buses.
- Serialises requests onto one internal single-port storage array using round-robin arbitration.
- Returns a one-cycle `ack` plus read data to the requesting core.
- Sits between the `Processor_Core` instances and data storage, replacing the direct multiport RAM attachment.

Parameters:
- mem_size, 4096, number of words in storage
- mem_width, 12, data word width in bits
- addr_width, 12, per-port address width in bits
- port_count, 2, number of requesting cores (>=1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req  input  port_count  per-port request; held high until ack
- wr  input  port_count  per-port write (1) / read (0); valid while req high
- address  input  addr_width*port_count  port j occupies bits [(j+1)*addr_width-1 : j*addr_width]
- datain  input  mem_width*port_count  write data, same slicing as address with mem_width
- ack  output  port_count  one-cycle completion pulse per port
- err  output  port_count  pulses with ack when the address was out of range
- dataout  output  mem_width*port_count  per-port read data, valid from the ack cycle
- grant_id  output  GW  index of the port granted in the previous cycle; GW = max(1, clog2(port_count))

Interface (already decided): one clock, `clk`; reset is `reset`, asynchronous and active-high.

Behaviour:
- Reset values (immediate, asynchronous):
  - ack = 0, err = 0, dataout = 0, grant_id = 0.
  - Round-robin pointer rr_ptr = 0.
  - Storage contents are not cleared.
- Eligibility per cycle: eligible = req & ~ack. A port being acked this cycle is masked, so a requester that drops req on seeing ack is never double-served.
- Arbitration (combinational):
  - Scan eligible cyclically starting at rr_ptr, wrapping from port_count-1 to 0.
  - The first set bit is granted port g.
  - No eligible port: no grant; rr_ptr and grant_id hold.
- On the rising edge with grant g:
  - Write, address < mem_size: mem[address_g] <= datain_g.
  - Read, address < mem_size: dataout_g <= mem[address_g].
  - address >= mem_size: no storage access; dataout_g <= 0; err[g] <= 1.
  - ack[g] <= 1 and all other ack bits <= 0; err is 0 for all ports except an errored g.
  - rr_ptr <= (g+1) mod port_count; grant_id <= g.
- Latency: request sampled at edge N, ack visible in cycle N+1 (1-cycle minimum).
- Fairness: a continuously requesting port is acked within port_count grant cycles.
- Read-after-write: a write committed at edge N is visible to any port's read granted at edge N+1 or later.
- dataout_j changes only on a read ack (or error ack) for port j; writes leave it unchanged.
- Requester may hold req after ack to issue a back-to-back request. Such a port is eligible again one cycle after its ack; it is re-served in cycle N+2 only if no other port wins.
- Reset mid-operation: a pending grant is discarded and no ack is issued. A write committed at the edge before reset assertion is retained.
- port_count = 1: rr_ptr is constant 0; maximum throughput is one access every 2 cycles due to ack masking.

Decomposition:
- Shared package mem_pkg:
  - clog2 function and GW width constant.
  - Default widths MEM_WIDTH=12, ADDR_WIDTH=12.
  - Request/response encoding constants RD=0, WR=1.
- Sub-module rr_arbiter (port_count): inputs eligible, rr_ptr; outputs grant_valid and grant index g.
- The responder owns rr_ptr, storage, and the ack/err/dataout registers.

Test Plan:
- Reset: assert reset mid-cycle -> ack, err, dataout, grant_id are 0 immediately, without waiting for a clock edge.
- Single-port access:
  - Port0 write addr 5 data 0xABC -> ack[0]=1 the next cycle.
  - Then port0 read addr 5 -> ack[0] with dataout[11:0]=0xABC.
- Collision:
  - Both ports request in the same cycle after reset (port0 write addr 7=0x111, port1 read addr 7) -> port0 acked first, grant_id=0.
  - Port1 acked the next cycle with dataout[23:12]=0x111, grant_id=1.
- Fairness: both ports hold req continuously for 10 cycles -> grant_id alternates 0,1,0,1; no port waits more than 2 grants.
- Out of range: mem_size=4000, port1 read addr 0xFA0 -> ack[1]=1, err[1]=1, dataout[23:12]=0, storage unchanged.
- Reset during a pending request: pulse reset while port0 req is high with no ack yet -> no ack that cycle; after release, the request is served with a 1-cycle ack.
